// File: rtl/fft_data_framer.sv
// Input-data stage for the FFT core: buffers an unframed ADC sample stream and frames it
// with tlast, holding off between frames so a committed config packet reaches the core first.
module fft_data_framer #(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned LOG2_MAX_LEN    = 10,
   parameter int unsigned FIFO_DEPTH_LOG2 = 4,
   parameter int unsigned HOLD_CYCLES     = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  enable,
   input  logic [4:0]            frame_len_log2,
   input  logic                  cfg_commit,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   output logic [31:0]           frame_count,
   output logic                  overflow,
   input  logic                  overflow_clr,
   output logic                  busy
);
   localparam int unsigned DEPTH = 2 ** FIFO_DEPTH_LOG2;
   localparam int unsigned AW    = FIFO_DEPTH_LOG2;
   localparam int unsigned CW    = FIFO_DEPTH_LOG2 + 1;
   localparam int unsigned SW    = LOG2_MAX_LEN;
   localparam int unsigned HW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, STREAM, HOLD} state_t;

   state_t                state, state_nx;
   logic [4:0]            l_q, l_nx;
   logic [SW-1:0]         cnt, cnt_nx;
   logic [HW-1:0]         hold_cnt, hold_nx;
   logic                  pend, pend_nx;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         fifo_cnt, occ;
   logic                  hs, last_hs, wr_req, drop, wr_en, ld_en, ld_last, flush;

   function automatic logic [4:0] clamp_l(input logic [4:0] l);
      if (l < 5'd3) return 5'd3;
      if ({27'd0, l} > LOG2_MAX_LEN) return 5'(LOG2_MAX_LEN);
      return l;
   endfunction

   function automatic logic [SW-1:0] last_idx(input logic [4:0] l);
      return {SW{1'b1}} >> (5'(LOG2_MAX_LEN) - l);
   endfunction

   // Next-state, frame counting and FIFO control
   always_comb begin
      state_nx = state;
      l_nx     = l_q;
      cnt_nx   = cnt;
      hold_nx  = hold_cnt;
      pend_nx  = pend;
      hs       = m_axis_tvalid & m_axis_tready;
      last_hs  = hs & m_axis_tlast;
      if (cfg_commit && state != IDLE) pend_nx = 1'b1;
      if (hs) cnt_nx = last_hs ? '0 : cnt + SW'(1);
      case (state)
         IDLE: begin
            if (enable) begin
               state_nx = STREAM;
               l_nx     = clamp_l(frame_len_log2);
               cnt_nx   = '0;
            end
         end
         STREAM: begin
            if (last_hs) begin
               if (!enable) begin
                  state_nx = IDLE;
               end else if (pend_nx) begin
                  state_nx = HOLD;
                  pend_nx  = 1'b0;
                  hold_nx  = '0;
               end else begin
                  l_nx = clamp_l(frame_len_log2);
               end
            end
         end
         HOLD: begin
            if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
               state_nx = enable ? STREAM : IDLE;
               l_nx     = clamp_l(frame_len_log2);
            end else begin
               hold_nx = hold_cnt + HW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
      if (state_nx == IDLE) pend_nx = 1'b0;
      // Occupancy includes the output register; a handshake frees a slot this cycle
      flush   = (state_nx == IDLE);
      occ     = fifo_cnt + CW'(m_axis_tvalid);
      wr_req  = s_axis_tvalid && (state != IDLE);
      drop    = wr_req && (occ == CW'(DEPTH)) && !hs;
      wr_en   = wr_req && !drop;
      ld_en   = (state_nx == STREAM) && (!m_axis_tvalid || hs) && (fifo_cnt != '0);
      ld_last = (cnt_nx == last_idx(l_nx));
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= s_axis_tdata;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= IDLE;
         l_q           <= 5'd3;
         cnt           <= '0;
         hold_cnt      <= '0;
         pend          <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_cnt      <= '0;
         s_axis_tready <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         frame_count   <= '0;
         overflow      <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state         <= state_nx;
         l_q           <= l_nx;
         cnt           <= cnt_nx;
         hold_cnt      <= hold_nx;
         pend          <= pend_nx;
         s_axis_tready <= 1'b1;
         busy          <= (state_nx != IDLE);
         if (last_hs) frame_count <= frame_count + 32'd1;
         if (drop) overflow <= 1'b1;
         else if (overflow_clr) overflow <= 1'b0;
         if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
         end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (ld_en) rd_ptr <= rd_ptr + AW'(1);
            fifo_cnt <= fifo_cnt + CW'(wr_en) - CW'(ld_en);
         end
         if (ld_en) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= mem[rd_ptr];
            m_axis_tlast  <= ld_last;
         end else if (hs) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_fft_data_framer.sv
// Bench for fft_data_framer: frame-length table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_fft_data_framer;
   localparam int HOLD = 4;

   logic        clk = 1'b0;
   logic        resetn, enable, cfg_commit, s_axis_tvalid, s_axis_tready;
   logic [4:0]  fl;
   logic [31:0] s_axis_tdata, m_axis_tdata, frame_count;
   logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, overflow, overflow_clr, busy;

   fft_data_framer dut (
      .clk(clk), .resetn(resetn), .enable(enable), .frame_len_log2(fl),
      .cfg_commit(cfg_commit), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tdata(s_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .frame_count(frame_count),
      .overflow(overflow), .overflow_clr(overflow_clr), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   logic [31:0] obs_d[$];
   bit          obs_l[$];
   int          obs_c[$];
   always @(negedge clk) begin
      if (resetn && m_axis_tvalid && m_axis_tready) begin
         obs_d.push_back(m_axis_tdata);
         obs_l.push_back(m_axis_tlast);
         obs_c.push_back(cyc_n);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_obs();
      obs_d.delete();
      obs_l.delete();
      obs_c.delete();
   endtask

   task automatic do_reset();
      resetn = 1'b0; enable = 1'b0; fl = 5'd3; cfg_commit = 1'b0;
      s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b0; overflow_clr = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      resetn = 1'b1;
      clear_obs();
   endtask

   // Reference model: samples held anywhere in the block, frame position and mode
   int          m_mode;   // 0 idle, 1 streaming, 2 guard gap
   logic [31:0] mq[$];
   int          m_l, m_idx, m_hold;
   bit          m_pend, m_ovf;
   int unsigned m_fc;

   function automatic int clampl(input int l);
      return (l < 3) ? 3 : ((l > 10) ? 10 : l);
   endfunction

   task automatic model_reset();
      m_mode = 0; mq.delete(); m_l = 3; m_idx = 0; m_hold = 0;
      m_pend = 0; m_ovf = 0; m_fc = 0;
   endtask

   task automatic model_check();
      chk("rnd_tready", s_axis_tready, 1'b1);
      chk("rnd_busy", busy, m_mode != 0);
      chk("rnd_frame_count", frame_count, m_fc);
      chk("rnd_overflow", overflow, m_ovf);
      if (m_mode != 1) chk("rnd_tvalid_gap", m_axis_tvalid, 1'b0);
      if (m_axis_tvalid) begin
         chk("rnd_nonempty", mq.size() > 0, 1'b1);
         if (mq.size() > 0) begin
            chk("rnd_tdata", m_axis_tdata, mq[0]);
            chk("rnd_tlast", m_axis_tlast, m_idx == (1 << m_l) - 1);
         end
      end
   endtask

   task automatic model_step();
      bit hs, last_hs, drop;
      hs      = m_axis_tvalid && m_axis_tready && (mq.size() > 0);
      last_hs = hs && (m_idx == (1 << m_l) - 1);
      drop    = (m_mode != 0) && s_axis_tvalid && (mq.size() == 16) && !hs;
      if (hs) begin
         void'(mq.pop_front());
         if (last_hs) begin
            m_idx = 0;
            m_fc++;
         end else begin
            m_idx++;
         end
      end
      if (m_mode != 0 && s_axis_tvalid && !drop) mq.push_back(s_axis_tdata);
      if (drop) m_ovf = 1;
      else if (overflow_clr) m_ovf = 0;
      if (m_mode != 0 && cfg_commit) m_pend = 1;
      case (m_mode)
         0: if (enable) begin m_mode = 1; m_l = clampl(int'(fl)); m_idx = 0; end
         1: if (last_hs) begin
               if (!enable) m_mode = 0;
               else if (m_pend) begin m_mode = 2; m_pend = 0; m_hold = HOLD; end
               else m_l = clampl(int'(fl));
            end
         default: begin
            m_hold--;
            if (m_hold == 0) begin
               if (enable) begin m_mode = 1; m_l = clampl(int'(fl)); end
               else m_mode = 0;
            end
         end
      endcase
      if (m_mode == 0) begin
         mq.delete();
         m_pend = 0;
      end
   endtask

   typedef struct {
      logic [4:0] fl;
      int         n;
   } len_vec_t;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      len_vec_t tbl[6];
      bit found, cdone;
      int pos;
      tbl[0] = '{5'd0, 8};   tbl[1] = '{5'd2, 8};   tbl[2] = '{5'd3, 8};
      tbl[3] = '{5'd4, 16};  tbl[4] = '{5'd6, 64};  tbl[5] = '{5'd31, 1024};

      // Reset values, checked while reset is held
      do_reset();
      resetn = 1'b0;
      #1;
      chk("rst_tvalid", m_axis_tvalid, 1'b0);
      chk("rst_tlast", m_axis_tlast, 1'b0);
      chk("rst_tdata", m_axis_tdata, 32'd0);
      chk("rst_frame_count", frame_count, 32'd0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_tready", s_axis_tready, 1'b0);
      cyc();
      resetn = 1'b1;
      cyc();
      chk("rst_tready_after", s_axis_tready, 1'b1);

      // Frame length per frame_len_log2, including clamping
      foreach (tbl[r]) begin
         do_reset();
         fl = tbl[r].fl; enable = 1'b1; m_axis_tready = 1'b1;
         cyc();
         found = 0;
         for (int k = 0; k < tbl[r].n + 50 && !found; k++) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = 32'(k + 1);
            cyc();
            if (obs_l.size() > 0 && obs_l[obs_l.size() - 1]) found = 1;
         end
         s_axis_tvalid = 1'b0;
         chk($sformatf("len_tlast_seen_fl%0d", tbl[r].fl), found, 1'b1);
         if (found) chk($sformatf("len_fl%0d", tbl[r].fl), obs_l.size(), tbl[r].n);
      end

      // T1: contiguous stream, N=8
      do_reset();
      fl = 5'd3; enable = 1'b1; m_axis_tready = 1'b1;
      cyc();
      for (int i = 0; i < 20; i++) begin
         s_axis_tvalid = 1'b1; s_axis_tdata = 32'(i + 1);
         cyc();
      end
      s_axis_tvalid = 1'b0;
      repeat (6) cyc();
      chk("t1_count", obs_d.size(), 20);
      for (int i = 0; i < obs_d.size(); i++) begin
         chk($sformatf("t1_data%0d", i), obs_d[i], 32'(i + 1));
         chk($sformatf("t1_last%0d", i), obs_l[i], (i == 7) || (i == 15));
      end
      chk("t1_frame_count", frame_count, 32'd2);
      chk("t1_overflow", overflow, 1'b0);

      // T2: back-pressure overflows the 16-deep buffer
      do_reset();
      fl = 5'd3; enable = 1'b1; m_axis_tready = 1'b0;
      cyc();
      for (int i = 0; i < 20; i++) begin
         s_axis_tvalid = 1'b1; s_axis_tdata = 32'(i + 1);
         cyc();
      end
      s_axis_tvalid = 1'b0;
      chk("t2_overflow_set", overflow, 1'b1);
      repeat (5) cyc();
      chk("t2_overflow_sticky", overflow, 1'b1);
      m_axis_tready = 1'b1;
      repeat (30) cyc();
      chk("t2_count", obs_d.size(), 16);
      for (int i = 0; i < obs_d.size(); i++) begin
         chk($sformatf("t2_data%0d", i), obs_d[i], 32'(i + 1));
         chk($sformatf("t2_last%0d", i), obs_l[i], (i == 7) || (i == 15));
      end
      chk("t2_frame_count", frame_count, 32'd2);
      chk("t2_overflow_before_clr", overflow, 1'b1);
      overflow_clr = 1'b1;
      cyc();
      overflow_clr = 1'b0;
      chk("t2_overflow_cleared", overflow, 1'b0);

      // T3: commit mid-frame produces a guard gap after the frame end
      do_reset();
      fl = 5'd4; enable = 1'b1; m_axis_tready = 1'b1;
      cyc();
      cdone = 0;
      for (int i = 0; i < 40; i++) begin
         s_axis_tvalid = 1'b1; s_axis_tdata = 32'(i + 1);
         cfg_commit = !cdone && (obs_d.size() == 5);
         if (cfg_commit) cdone = 1;
         cyc();
      end
      s_axis_tvalid = 1'b0; cfg_commit = 1'b0;
      repeat (20) cyc();
      chk("t3_count", obs_d.size(), 40);
      for (int i = 0; i < obs_d.size(); i++) begin
         chk($sformatf("t3_data%0d", i), obs_d[i], 32'(i + 1));
         chk($sformatf("t3_last%0d", i), obs_l[i], (i == 15) || (i == 31));
      end
      if (obs_c.size() > 16) begin
         chk("t3_no_gap_before_end", obs_c[15] - obs_c[14], 1);
         chk("t3_hold_gap", obs_c[16] - obs_c[15], HOLD + 1);
      end
      chk("t3_frame_count", frame_count, 32'd2);

      // T4: length change mid-frame applies from the next frame
      do_reset();
      fl = 5'd3; enable = 1'b1; m_axis_tready = 1'b1;
      cyc();
      for (int i = 0; i < 45; i++) begin
         if (obs_d.size() == 3) fl = 5'd5;
         s_axis_tvalid = 1'b1; s_axis_tdata = 32'(i + 1);
         cyc();
      end
      s_axis_tvalid = 1'b0;
      repeat (6) cyc();
      chk("t4_count", obs_d.size(), 45);
      for (int i = 0; i < obs_l.size(); i++)
         chk($sformatf("t4_last%0d", i), obs_l[i], (i == 7) || (i == 39));

      // T5: enable drop mid-frame completes the frame, then idles
      do_reset();
      fl = 5'd3; enable = 1'b1; m_axis_tready = 1'b1;
      cyc();
      for (int i = 0; i < 12; i++) begin
         if (obs_d.size() == 2) enable = 1'b0;
         s_axis_tvalid = 1'b1; s_axis_tdata = 32'(i + 1);
         cyc();
      end
      s_axis_tvalid = 1'b0;
      repeat (5) cyc();
      chk("t5_count", obs_d.size(), 8);
      if (obs_l.size() == 8) chk("t5_last", obs_l[7], 1'b1);
      chk("t5_frame_count", frame_count, 32'd1);
      chk("t5_busy", busy, 1'b0);
      chk("t5_tvalid", m_axis_tvalid, 1'b0);
      for (int i = 0; i < 3; i++) begin
         s_axis_tvalid = 1'b1; s_axis_tdata = 32'(50 + i);
         cyc();
      end
      s_axis_tvalid = 1'b0;
      repeat (4) cyc();
      chk("t5_idle_discard", obs_d.size(), 8);
      enable = 1'b1;
      cyc();
      for (int i = 0; i < 3; i++) begin
         s_axis_tvalid = 1'b1; s_axis_tdata = 32'(100 + i);
         cyc();
      end
      s_axis_tvalid = 1'b0;
      repeat (5) cyc();
      if (obs_d.size() > 8) chk("t5_first_after_idle", obs_d[8], 32'd100);
      else chk("t5_restart_count", obs_d.size(), 11);

      // T6: reset mid-frame abandons the partial frame
      do_reset();
      fl = 5'd3; enable = 1'b1; m_axis_tready = 1'b1;
      cyc();
      for (int i = 0; i < 20 && obs_d.size() < 5; i++) begin
         s_axis_tvalid = 1'b1; s_axis_tdata = 32'(i + 1);
         cyc();
      end
      resetn = 1'b0;
      #1;
      chk("t6_tvalid", m_axis_tvalid, 1'b0);
      chk("t6_tlast", m_axis_tlast, 1'b0);
      chk("t6_tdata", m_axis_tdata, 32'd0);
      chk("t6_busy", busy, 1'b0);
      chk("t6_tready", s_axis_tready, 1'b0);
      s_axis_tvalid = 1'b0;
      cyc();
      resetn = 1'b1;
      clear_obs();
      cyc();
      for (int i = 0; i < 12; i++) begin
         s_axis_tvalid = 1'b1; s_axis_tdata = 32'(200 + i);
         cyc();
      end
      s_axis_tvalid = 1'b0;
      repeat (6) cyc();
      chk("t6_count", obs_d.size(), 12);
      for (int i = 0; i < obs_d.size(); i++) begin
         chk($sformatf("t6_data%0d", i), obs_d[i], 32'(200 + i));
         chk($sformatf("t6_last%0d", i), obs_l[i], i == 7);
      end
      chk("t6_frame_count", frame_count, 32'd1);

      // Randomized run against the reference model
      do_reset();
      model_reset();
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk);
         #2;
         enable        = ($urandom_range(0, 99) < 95);
         fl            = 5'($urandom_range(0, 5));
         cfg_commit    = ($urandom_range(0, 19) == 0);
         s_axis_tvalid = ($urandom_range(0, 3) != 0);
         s_axis_tdata  = $urandom;
         m_axis_tready = ($urandom_range(0, 2) != 0);
         overflow_clr  = ($urandom_range(0, 29) == 0);
         @(negedge clk);
         model_check();
         model_step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
